vga_overlay_ctrl: RTL and testbench
===================================

// Module: vga_overlay_ctrl
// PURPOSE
// Frame-synchronous controller for the VGA rectangle-overlay pixel datapath. Holds NRECT
// rectangles in a shadow bank written over a valid/ready config port. On request, copies the
// shadow bank to the active bank during vertical blanking, so a frame never tears. Each pixel
// strobe, resolves overlapping rectangles by fixed priority and drives disp_R/G/B.
// Sits between the timing generator (xpos/ypos/dat_act/vblank_start) and the DAC pins.
// PARAMETERS
// NRECT  4   number of rectangles; index width IW = $clog2(NRECT)
// CW     10  coordinate width, matches hcount/vcount
// PORTS
// clock         in   1   system clock (50 MHz)
// reset         in   1   synchronous, active-high
// pix_ce        in   1   pixel strobe, one clock in two (25 MHz pixel rate)
// vblank_start  in   1   1-strobe pulse at first blank line; only valid when pix_ce=1
// dat_act       in   1   visible-area flag from the timing generator
// xpos, ypos    in   CW  visible-area coordinates (hcount-143, vcount-34)
// bg_rgb        in   3   background colour {R,G,B}
// cfg_valid     in   1   config write request
// cfg_ready     out  1   config write accept
// cfg_idx       in   IW  rectangle index
// cfg_x0/x1/y0/y1 in CW  inclusive bounds
// cfg_rgb       in   3   rectangle colour
// cfg_en        in   1   rectangle enable
// commit_req    in   1   pulse: request shadow->active copy at next vblank
// commit_busy   out  1   high while state != IDLE
// commit_done   out  1   one-cycle pulse after copy completes
// disp_R/G/B    out  1   registered pixel colour
// BEHAVIOUR
// - Reset: both banks cleared (en=0, coords=0, rgb=0); state IDLE; disp_*=0; commit_done=0;
//   commit_busy=0; cfg_ready=0 in the reset cycle, 1 from the next cycle. Reset mid-COMMIT
//   aborts the copy and clears the active bank.
// - Config write: accepted on an edge where cfg_valid&&cfg_ready; the shadow entry is updated on
//   that edge. cfg_ready = (state != COMMIT). The active bank is never written by the port.
// - FSM:
//   - IDLE -> PENDING on commit_req.
//   - PENDING -> COMMIT on (vblank_start && pix_ce); commit_req in PENDING is absorbed.
//   - COMMIT lasts exactly NRECT cycles, copying entry k on its k-th cycle (k=0..NRECT-1).
//     It then goes to IDLE, or to PENDING if commit_req arrived during COMMIT (requeue flag).
//   - commit_done is high for the single cycle after the last COMMIT cycle, including on requeue.
// - Simultaneous events:
//   - commit_req && vblank_start in IDLE -> PENDING only; the copy waits for the next vblank.
//   - A write accepted on the PENDING->COMMIT edge is included in the copy.
//   - vblank_start in IDLE or COMMIT is ignored.
// - Pixel path (updates only on edges with pix_ce=1, holds otherwise; latency 1 strobe):
//   - hit[i] = en[i] && x0<=xpos<=x1 && y0<=ypos<=y1, unsigned and inclusive; x0>x1 or y0>y1
//     never hits.
//   - Lowest hit index wins. Colour = !dat_act ? 3'b000 : any hit ? rgb[winner] : bg_rgb.
//   - The pixel path reads only the active bank. A copy during COMMIT is visible on the next
//     strobe, which is in blanking.
// STRUCTURE
// - package vga_pkg:
//   - CW and timing constants (HSYNC_END 95, HDAT_BEGIN 143, HDAT_END 783, HPIXEL_END 799,
//     VSYNC_END 1, VDAT_BEGIN 34, VDAT_END 514, VLINE_END 524).
//   - rgb_t (3 bits); rect_t {x0,x1,y0,y1,rgb,en}; ovl_state_t {IDLE,PENDING,COMMIT}.
// - Sub-module vga_rect_hit: combinational inclusive-bounds compare of one rect_t against
//   xpos/ypos, instantiated NRECT times. The priority encoder and FSM stay in the top level.
// TESTING
// 1 Reset, dat_act=1, bg_rgb=3'b001, xpos=10 -> disp=001 one strobe later; cfg_ready=1;
//   commit_busy=0.
// 2 Write idx0 {120,140,80,400,rgb=100,en=1}, no commit -> (130,200) stays 001. Then
//   commit_req + vblank_start -> busy high, COMMIT 4 cycles, commit_done 1 cycle -> (130,200)=100.
// 3 idx0 x 100..200, rgb 100; idx1 x 150..250, rgb 010; y 0..479 -> x=175:100; x=200:100;
//   x=225:010; x=251:001. dat_act=0 -> 000. idx2 x0=300,x1=290 -> never hits.
// 4 cfg_valid held from the COMMIT entry edge -> cfg_ready=0 for 4 cycles; write accepted on
//   the first IDLE cycle.
// 5 commit_req during COMMIT -> commit_done pulses, state PENDING, second copy on the next
//   vblank_start only.
// 6 reset asserted on the 2nd COMMIT cycle -> next strobe shows bg_rgb everywhere; shadow cleared.

Source files
------------

// File: rtl/vga_pkg.sv
`timescale 1ns/1ps
// Shared types and VGA 640x480 timing constants for the rectangle-overlay datapath.
package vga_pkg;
  localparam int CW = 10;

  localparam int HSYNC_END  = 95;
  localparam int HDAT_BEGIN = 143;
  localparam int HDAT_END   = 783;
  localparam int HPIXEL_END = 799;
  localparam int VSYNC_END  = 1;
  localparam int VDAT_BEGIN = 34;
  localparam int VDAT_END   = 514;
  localparam int VLINE_END  = 524;

  typedef logic [2:0] rgb_t;

  typedef struct packed {
    logic [CW-1:0] x0;
    logic [CW-1:0] x1;
    logic [CW-1:0] y0;
    logic [CW-1:0] y1;
    rgb_t          rgb;
    logic          en;
  } rect_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    COMMIT  = 2'd2
  } ovl_state_t;
endpackage

// File: rtl/vga_rect_hit.sv
`timescale 1ns/1ps
// Inclusive-bounds hit test of one rectangle against the current pixel.
// An inverted rectangle (x0>x1 or y0>y1) can never satisfy both compares.
module vga_rect_hit
  import vga_pkg::*;
(
  input  rect_t         i_rect,
  input  logic [CW-1:0] i_xpos,
  input  logic [CW-1:0] i_ypos,
  output logic          o_hit
);
  assign o_hit = i_rect.en
              && (i_xpos >= i_rect.x0) && (i_xpos <= i_rect.x1)
              && (i_ypos >= i_rect.y0) && (i_ypos <= i_rect.y1);
endmodule

// File: rtl/vga_overlay_ctrl.sv
`timescale 1ns/1ps
// Rectangle-overlay controller: shadow/active rectangle banks, tear-free commit during
// vertical blanking, and fixed-priority colour resolution per pixel strobe.
module vga_overlay_ctrl #(
  parameter  int NRECT = 4,
  parameter  int CW    = 10,
  localparam int IW    = (NRECT > 1) ? $clog2(NRECT) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          pix_ce,
  input  logic          vblank_start,
  input  logic          dat_act,
  input  logic [CW-1:0] xpos,
  input  logic [CW-1:0] ypos,
  input  logic [2:0]    bg_rgb,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [IW-1:0] cfg_idx,
  input  logic [CW-1:0] cfg_x0,
  input  logic [CW-1:0] cfg_x1,
  input  logic [CW-1:0] cfg_y0,
  input  logic [CW-1:0] cfg_y1,
  input  logic [2:0]    cfg_rgb,
  input  logic          cfg_en,
  input  logic          commit_req,
  output logic          commit_busy,
  output logic          commit_done,
  output logic          disp_R,
  output logic          disp_G,
  output logic          disp_B
);
  import vga_pkg::*;

  rect_t            r_shadow [NRECT];
  rect_t            r_active [NRECT];
  ovl_state_t       r_state;
  ovl_state_t       w_state_nxt;
  logic [IW-1:0]    r_k;
  logic             r_requeue;
  logic             r_done;
  logic [2:0]       r_disp;
  logic [NRECT-1:0] w_hit;
  logic             w_any;
  rgb_t             w_win_rgb;
  logic             w_last;
  logic             w_cfg_fire;

  assign w_last     = (r_state == COMMIT) && (r_k == IW'(NRECT - 1));
  assign cfg_ready  = !reset && (r_state != COMMIT);
  assign w_cfg_fire = cfg_valid && cfg_ready;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (commit_req) w_state_nxt = PENDING;
      PENDING: if (vblank_start && pix_ce) w_state_nxt = COMMIT;
      COMMIT:  if (w_last) w_state_nxt = (r_requeue || commit_req) ? PENDING : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Requests arriving mid-copy are remembered so the FSM re-arms instead of dropping them.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_k       <= '0;
      r_requeue <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_last;
      if (r_state == COMMIT) begin
        r_k       <= w_last ? '0 : r_k + 1'b1;
        r_requeue <= w_last ? 1'b0 : (r_requeue | commit_req);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NRECT; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      if (w_cfg_fire)
        r_shadow[cfg_idx] <= '{x0: cfg_x0, x1: cfg_x1, y0: cfg_y0, y1: cfg_y1,
                               rgb: cfg_rgb, en: cfg_en};
      if (r_state == COMMIT)
        r_active[r_k] <= r_shadow[r_k];
    end
  end

  for (genvar g = 0; g < NRECT; g++) begin : g_hit
    vga_rect_hit u_hit (
      .i_rect (r_active[g]),
      .i_xpos (xpos),
      .i_ypos (ypos),
      .o_hit  (w_hit[g])
    );
  end

  // Scan from the highest index down so the lowest hitting index is written last and wins.
  always_comb begin
    w_any     = 1'b0;
    w_win_rgb = '0;
    for (int i = NRECT - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_any     = 1'b1;
        w_win_rgb = r_active[i].rgb;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset)
      r_disp <= '0;
    else if (pix_ce)
      r_disp <= !dat_act ? 3'b000 : (w_any ? w_win_rgb : bg_rgb);
  end

  assign commit_busy = (r_state != IDLE);
  assign commit_done = r_done;
  assign disp_R      = r_disp[2];
  assign disp_G      = r_disp[1];
  assign disp_B      = r_disp[0];
endmodule

// File: tb/tb_vga_overlay_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for vga_overlay_ctrl: directed scenarios plus randomized rectangles
// checked against a behavioural rectangle/priority model.
module tb_vga_overlay_ctrl;
  localparam int NRECT = 4;
  localparam int CW    = 10;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          pix_ce = 1'b0;
  logic          vblank_start = 1'b0;
  logic          dat_act = 1'b0;
  logic [CW-1:0] xpos = '0;
  logic [CW-1:0] ypos = '0;
  logic [2:0]    bg_rgb = '0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [1:0]    cfg_idx = '0;
  logic [CW-1:0] cfg_x0 = '0;
  logic [CW-1:0] cfg_x1 = '0;
  logic [CW-1:0] cfg_y0 = '0;
  logic [CW-1:0] cfg_y1 = '0;
  logic [2:0]    cfg_rgb = '0;
  logic          cfg_en = 1'b0;
  logic          commit_req = 1'b0;
  logic          commit_busy;
  logic          commit_done;
  logic          disp_R, disp_G, disp_B;
  logic [2:0]    disp;

  assign disp = {disp_R, disp_G, disp_B};

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int         x0, x1, y0, y1;
    logic [2:0] rgb;
    bit         en;
  } mrect_t;

  mrect_t m_shadow [NRECT];
  mrect_t m_active [NRECT];

  vga_overlay_ctrl #(.NRECT(NRECT), .CW(CW)) dut (
    .clock        (clock),
    .reset        (reset),
    .pix_ce       (pix_ce),
    .vblank_start (vblank_start),
    .dat_act      (dat_act),
    .xpos         (xpos),
    .ypos         (ypos),
    .bg_rgb       (bg_rgb),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_idx      (cfg_idx),
    .cfg_x0       (cfg_x0),
    .cfg_x1       (cfg_x1),
    .cfg_y0       (cfg_y0),
    .cfg_y1       (cfg_y1),
    .cfg_rgb      (cfg_rgb),
    .cfg_en       (cfg_en),
    .commit_req   (commit_req),
    .commit_busy  (commit_busy),
    .commit_done  (commit_done),
    .disp_R       (disp_R),
    .disp_G       (disp_G),
    .disp_B       (disp_B)
  );

  always #10 clock = ~clock;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Expected colour from the rules: blank -> black, else lowest enabled inclusive hit, else bg.
  function automatic logic [2:0] model_rgb(input int x, input int y, input bit da,
                                           input logic [2:0] bg);
    if (!da) return 3'b000;
    for (int i = 0; i < NRECT; i++)
      if (m_active[i].en && x >= m_active[i].x0 && x <= m_active[i].x1 &&
          y >= m_active[i].y0 && y <= m_active[i].y1)
        return m_active[i].rgb;
    return bg;
  endfunction

  task automatic clear_models();
    for (int i = 0; i < NRECT; i++) begin
      m_shadow[i] = '{0, 0, 0, 0, 3'b000, 1'b0};
      m_active[i] = '{0, 0, 0, 0, 3'b000, 1'b0};
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    pix_ce = ~pix_ce;
  endtask

  task automatic strobe();
    if (!pix_ce) step();
    step();
  endtask

  task automatic show(input int x, input int y, input bit da, input logic [2:0] bg);
    xpos = CW'(x);
    ypos = CW'(y);
    dat_act = da;
    bg_rgb = bg;
    strobe();
  endtask

  task automatic vblank_pulse();
    if (!pix_ce) step();
    vblank_start = 1'b1;
    step();
    vblank_start = 1'b0;
  endtask

  task automatic write_rect(input int idx, input int x0, input int x1, input int y0,
                            input int y1, input logic [2:0] rgb, input bit en);
    int waited = 0;
    cfg_idx = 2'(idx);
    cfg_x0 = CW'(x0);
    cfg_x1 = CW'(x1);
    cfg_y0 = CW'(y0);
    cfg_y1 = CW'(y1);
    cfg_rgb = rgb;
    cfg_en = en;
    cfg_valid = 1'b1;
    while (!cfg_ready && waited < 20) begin
      step();
      waited++;
    end
    n_cmp++;
    if (cfg_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL cfg_accept: cfg_ready=%b after %0d cycles, required 1", cfg_ready, waited);
    end
    step();
    cfg_valid = 1'b0;
    m_shadow[idx] = '{x0, x1, y0, y1, rgb, en};
  endtask

  task automatic do_commit();
    int t = 0;
    commit_req = 1'b1;
    step();
    commit_req = 1'b0;
    vblank_pulse();
    while (!commit_done && t < 20) begin
      step();
      t++;
    end
    n_cmp++;
    if (commit_done !== 1'b1) begin
      n_bad++;
      $display("FAIL commit_timeout: commit_done=%b after %0d cycles, required 1", commit_done, t);
    end
    for (int i = 0; i < NRECT; i++) m_active[i] = m_shadow[i];
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    dat_act = 1'b1;
    bg_rgb = 3'b001;
    xpos = 10'd10;
    ypos = 10'd0;
    clear_models();
    step();
    step();
    n_cmp++;
    if (cfg_ready !== 1'b0) begin
      n_bad++; $display("FAIL reset_ready: got %b, required 0", cfg_ready);
    end
    n_cmp++;
    if ({commit_busy, commit_done} !== 2'b00) begin
      n_bad++; $display("FAIL reset_busy_done: got %b, required 00", {commit_busy, commit_done});
    end
    n_cmp++;
    if (disp !== 3'b000) begin
      n_bad++; $display("FAIL reset_disp: got %b, required 000", disp);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (cfg_ready !== 1'b1) begin
      n_bad++; $display("FAIL post_reset_ready: got %b, required 1", cfg_ready);
    end
    strobe();
    n_cmp++;
    if (disp !== 3'b001) begin
      n_bad++; $display("FAIL reset_bg_pixel: got %b, required 001", disp);
    end
    n_cmp++;
    if (commit_busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_idle_busy: got %b, required 0", commit_busy);
    end
  endtask

  task automatic test_commit_basic();
    write_rect(0, 120, 140, 80, 400, 3'b100, 1'b1);
    show(130, 200, 1'b1, 3'b001);
    n_cmp++;
    if (disp !== 3'b001) begin
      n_bad++; $display("FAIL shadow_not_visible: got %b, required 001", disp);
    end
    // commit_req and vblank_start on the same edge only arm the copy
    if (!pix_ce) step();
    commit_req = 1'b1;
    vblank_start = 1'b1;
    step();
    commit_req = 1'b0;
    vblank_start = 1'b0;
    step();
    step();
    n_cmp++;
    if ({commit_busy, cfg_ready} !== 2'b11) begin
      n_bad++; $display("FAIL pending_wait: busy,ready got %b, required 11", {commit_busy, cfg_ready});
    end
    vblank_pulse();
    for (int c = 0; c < NRECT; c++) begin
      n_cmp++;
      if ({commit_busy, cfg_ready, commit_done} !== 3'b100) begin
        n_bad++;
        $display("FAIL commit_cycle%0d: busy,ready,done got %b, required 100", c,
                 {commit_busy, cfg_ready, commit_done});
      end
      step();
    end
    n_cmp++;
    if ({commit_busy, cfg_ready, commit_done} !== 3'b011) begin
      n_bad++;
      $display("FAIL commit_end: busy,ready,done got %b, required 011",
               {commit_busy, cfg_ready, commit_done});
    end
    step();
    n_cmp++;
    if (commit_done !== 1'b0) begin
      n_bad++; $display("FAIL done_single_cycle: got %b, required 0", commit_done);
    end
    for (int i = 0; i < NRECT; i++) m_active[i] = m_shadow[i];
    show(130, 200, 1'b1, 3'b001);
    n_cmp++;
    if (disp !== 3'b100) begin
      n_bad++; $display("FAIL commit_visible: got %b, required 100", disp);
    end
    show(140, 400, 1'b1, 3'b001);
    n_cmp++;
    if (disp !== 3'b100) begin
      n_bad++; $display("FAIL corner_inclusive: got %b, required 100", disp);
    end
    show(141, 400, 1'b1, 3'b001);
    n_cmp++;
    if (disp !== 3'b001) begin
      n_bad++; $display("FAIL corner_outside: got %b, required 001", disp);
    end
  endtask

  task automatic test_priority();
    int         xs  [9] = '{175, 200, 225, 251, 100, 99, 295, 290, 300};
    logic [2:0] exp [9] = '{3'b100, 3'b100, 3'b010, 3'b001, 3'b100, 3'b001, 3'b001, 3'b001, 3'b001};
    write_rect(0, 100, 200, 0, 479, 3'b100, 1'b1);
    write_rect(1, 150, 250, 0, 479, 3'b010, 1'b1);
    write_rect(2, 300, 290, 0, 479, 3'b111, 1'b1);
    write_rect(3, 0, 0, 0, 0, 3'b000, 1'b0);
    do_commit();
    for (int i = 0; i < 9; i++) begin
      show(xs[i], 240, 1'b1, 3'b001);
      n_cmp++;
      if (disp !== exp[i]) begin
        n_bad++; $display("FAIL priority_x%0d: got %b, required %b", xs[i], disp, exp[i]);
      end
    end
    show(175, 240, 1'b0, 3'b001);
    n_cmp++;
    if (disp !== 3'b000) begin
      n_bad++; $display("FAIL blanking: got %b, required 000", disp);
    end
    show(175, 240, 1'b1, 3'b001);
    xpos = 10'd251;
    step();
    n_cmp++;
    if (disp !== 3'b100) begin
      n_bad++; $display("FAIL hold_no_strobe: got %b, required 100", disp);
    end
    step();
    n_cmp++;
    if (disp !== 3'b001) begin
      n_bad++; $display("FAIL update_on_strobe: got %b, required 001", disp);
    end
  endtask

  task automatic test_cfg_block();
    int zeros = 0;
    commit_req = 1'b1;
    step();
    commit_req = 1'b0;
    vblank_pulse();
    cfg_idx = 2'd3;
    cfg_x0 = 10'd400;
    cfg_x1 = 10'd420;
    cfg_y0 = 10'd400;
    cfg_y1 = 10'd420;
    cfg_rgb = 3'b110;
    cfg_en = 1'b1;
    cfg_valid = 1'b1;
    while (!cfg_ready && zeros < 10) begin
      zeros++;
      step();
    end
    n_cmp++;
    if (zeros !== NRECT) begin
      n_bad++; $display("FAIL cfg_block_cycles: ready low for %0d cycles, required %0d", zeros, NRECT);
    end
    n_cmp++;
    if (commit_done !== 1'b1) begin
      n_bad++; $display("FAIL cfg_first_idle: commit_done got %b, required 1", commit_done);
    end
    for (int i = 0; i < NRECT; i++) m_active[i] = m_shadow[i];
    step();
    cfg_valid = 1'b0;
    m_shadow[3] = '{400, 420, 400, 420, 3'b110, 1'b1};
    show(410, 410, 1'b1, 3'b001);
    n_cmp++;
    if (disp !== 3'b001) begin
      n_bad++; $display("FAIL late_write_not_active: got %b, required 001", disp);
    end
    do_commit();
    show(410, 410, 1'b1, 3'b001);
    n_cmp++;
    if (disp !== 3'b110) begin
      n_bad++; $display("FAIL late_write_committed: got %b, required 110", disp);
    end
  endtask

  task automatic test_requeue();
    int t = 0;
    commit_req = 1'b1;
    step();
    commit_req = 1'b0;
    vblank_pulse();
    step();
    commit_req = 1'b1;
    step();
    commit_req = 1'b0;
    step();
    step();
    n_cmp++;
    if ({commit_done, commit_busy, cfg_ready} !== 3'b111) begin
      n_bad++;
      $display("FAIL requeue_end: done,busy,ready got %b, required 111",
               {commit_done, commit_busy, cfg_ready});
    end
    for (int i = 0; i < NRECT; i++) m_active[i] = m_shadow[i];
    write_rect(0, 0, 50, 0, 50, 3'b011, 1'b1);
    show(25, 25, 1'b1, 3'b001);
    n_cmp++;
    if (disp !== 3'b001) begin
      n_bad++; $display("FAIL requeue_no_copy_yet: got %b, required 001", disp);
    end
    if (pix_ce) step();
    vblank_start = 1'b1;
    step();
    vblank_start = 1'b0;
    n_cmp++;
    if ({commit_busy, cfg_ready} !== 2'b11) begin
      n_bad++; $display("FAIL vblank_no_strobe: busy,ready got %b, required 11", {commit_busy, cfg_ready});
    end
    vblank_pulse();
    while (!commit_done && t < 20) begin
      step();
      t++;
    end
    n_cmp++;
    if (t !== NRECT) begin
      n_bad++; $display("FAIL requeue_copy_len: done after %0d cycles, required %0d", t, NRECT);
    end
    for (int i = 0; i < NRECT; i++) m_active[i] = m_shadow[i];
    step();
    n_cmp++;
    if (commit_busy !== 1'b0) begin
      n_bad++; $display("FAIL requeue_idle: busy got %b, required 0", commit_busy);
    end
    show(25, 25, 1'b1, 3'b001);
    n_cmp++;
    if (disp !== 3'b011) begin
      n_bad++; $display("FAIL requeue_copy: got %b, required 011", disp);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NRECT; i++)
        write_rect(i, $urandom_range(0, 639), $urandom_range(0, 639), $urandom_range(0, 479),
                   $urandom_range(0, 479), 3'($urandom_range(0, 7)), $urandom_range(0, 3) != 0);
      do_commit();
      for (int p = 0; p < 40; p++) begin
        int x = $urandom_range(0, 639);
        int y = $urandom_range(0, 479);
        bit da = $urandom_range(0, 7) != 0;
        logic [2:0] bg = 3'($urandom_range(0, 7));
        logic [2:0] exp;
        if ($urandom_range(0, 1) != 0) begin
          int j = $urandom_range(0, NRECT - 1);
          x = ($urandom_range(0, 1) != 0 ? m_active[j].x0 : m_active[j].x1) + $urandom_range(0, 2) - 1;
          y = ($urandom_range(0, 1) != 0 ? m_active[j].y0 : m_active[j].y1) + $urandom_range(0, 2) - 1;
          if (x < 0) x = 0;
          if (y < 0) y = 0;
        end
        exp = model_rgb(x, y, da, bg);
        show(x, y, da, bg);
        n_cmp++;
        if (disp !== exp) begin
          n_bad++; $display("FAIL random_pixel(%0d,%0d): got %b, required %b", x, y, disp, exp);
        end
      end
    end
  endtask

  task automatic test_reset_mid_commit();
    write_rect(0, 0, 639, 0, 479, 3'b101, 1'b1);
    do_commit();
    show(320, 240, 1'b1, 3'b001);
    n_cmp++;
    if (disp !== 3'b101) begin
      n_bad++; $display("FAIL pre_abort_pixel: got %b, required 101", disp);
    end
    commit_req = 1'b1;
    step();
    commit_req = 1'b0;
    vblank_pulse();
    step();
    reset = 1'b1;
    #1;
    n_cmp++;
    if (cfg_ready !== 1'b0) begin
      n_bad++; $display("FAIL abort_ready: got %b, required 0", cfg_ready);
    end
    step();
    reset = 1'b0;
    clear_models();
    #1;
    n_cmp++;
    if ({commit_busy, commit_done, cfg_ready, disp} !== 6'b001000) begin
      n_bad++;
      $display("FAIL abort_state: busy,done,ready,disp got %b, required 001000",
               {commit_busy, commit_done, cfg_ready, disp});
    end
    step();
    n_cmp++;
    if (commit_done !== 1'b0) begin
      n_bad++; $display("FAIL abort_no_done: got %b, required 0", commit_done);
    end
    show(320, 240, 1'b1, 3'b010);
    n_cmp++;
    if (disp !== 3'b010) begin
      n_bad++; $display("FAIL abort_active_cleared: got %b, required 010", disp);
    end
    do_commit();
    show(10, 10, 1'b1, 3'b011);
    n_cmp++;
    if (disp !== 3'b011) begin
      n_bad++; $display("FAIL abort_shadow_cleared: got %b, required 011", disp);
    end
  endtask

  initial begin
    test_reset();
    test_commit_basic();
    test_priority();
    test_cfg_block();
    test_requeue();
    test_random();
    test_reset_mid_commit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
